panel_deposit: RTL

Front-panel register deposit engine: the write-direction counterpart to the register readout path. It takes a debounced DEPOSIT button, a register select and an 8-bit value from the panel, and writes the value into the control-RAM mailbox slot (0xF0–0xF6) through the RAM's second write port. It keeps a pending-register bitmask mirrored at 0xFA and holds a CPU interrupt request until the monitor acknowledges by reading 0xFA.

---
 rtl/panel_deposit_if.sv | 20 ++
 rtl/panel_deposit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/panel_deposit_if.sv
// Control-RAM side of the deposit engine: CPU bus snoop inputs plus the
// RAM second write port driven by the engine.
interface panel_deposit_if;
  logic       csP;
  logic [7:0] A;
  logic       write;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  modport master (
    input  csP, A, write,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    output csP, A, write,
    input  wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/panel_deposit.sv
// Front-panel register deposit engine: debounces DEPOSIT, writes the value into
// its mailbox slot, then mirrors the pending mask and raises irq until acked.
module panel_deposit #(
  parameter int         DEBOUNCE_CYCLES = 65536,
  parameter logic [7:0] MAILBOX_BASE    = 8'hF0,
  parameter logic [7:0] MASK_ADDR       = 8'hFA
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   deposit_btn,
  input  logic [2:0]             sel,
  input  logic [7:0]             val,
  panel_deposit_if.master        bus,
  output logic [6:0]             pend_mask,
  output logic                   irq_n,
  output logic                   busy
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_REG  = 2'd1,
    WR_MASK = 2'd2
  } state_t;

  logic             sync1_reg;
  logic             sync2_reg;
  logic             db_reg;
  logic             dep_pulse_reg;
  logic [CNT_W-1:0] cnt_reg;

  state_t           state_reg;
  state_t           state_next;
  logic [2:0]       sel_q_reg;
  logic [2:0]       sel_q_next;
  logic [7:0]       val_q_reg;
  logic [7:0]       val_q_next;
  logic [6:0]       mask_reg;
  logic [6:0]       mask_next;
  logic             irq_n_reg;

  logic             ack;
  logic             set;

  // Synchronizer + debouncer; the counter only runs while the level disagrees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg     <= 1'b0;
      sync2_reg     <= 1'b0;
      db_reg        <= 1'b0;
      dep_pulse_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      sync1_reg     <= deposit_btn;
      sync2_reg     <= sync1_reg;
      dep_pulse_reg <= 1'b0;
      if (sync2_reg == db_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        db_reg        <= sync2_reg;
        cnt_reg       <= '0;
        dep_pulse_reg <= sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign ack = bus.csP & ~bus.write & (bus.A == MASK_ADDR);
  assign set = (state_reg == WR_REG);

  // An ack clears the old bits; a set in the same cycle still lands.
  for (genvar gi = 0; gi < 7; gi++) begin : g_mask
    assign mask_next[gi] = (~ack & mask_reg[gi]) | (set & (sel_q_reg == 3'(gi)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sel_q_reg <= 3'd0;
      val_q_reg <= 8'd0;
      mask_reg  <= 7'd0;
      irq_n_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      sel_q_reg <= sel_q_next;
      val_q_reg <= val_q_next;
      mask_reg  <= mask_next;
      irq_n_reg <= ~(|mask_next);
    end
  end

  always_comb begin
    state_next  = state_reg;
    sel_q_next  = sel_q_reg;
    val_q_next  = val_q_reg;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 8'd0;
    bus.wr_data = 8'd0;
    case (state_reg)
      IDLE: begin
        if (dep_pulse_reg && (sel != 3'd7)) begin
          state_next = WR_REG;
          sel_q_next = sel;
          val_q_next = val;
        end else if (ack) begin
          state_next = WR_MASK;
        end
      end
      WR_REG: begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = MAILBOX_BASE + {5'd0, sel_q_reg};
        bus.wr_data = val_q_reg;
        state_next  = WR_MASK;
      end
      WR_MASK: begin
        // Mirror carries this cycle's update, so an ack here is already reflected.
        bus.wr_en   = 1'b1;
        bus.wr_addr = MASK_ADDR;
        bus.wr_data = {1'b0, mask_next};
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pend_mask = mask_reg;
  assign irq_n     = irq_n_reg;
  assign busy      = (state_reg != IDLE);

endmodule
